mdu: RTL and testbench
======================

# mdu

Parametrised iterative multiply/divide unit for the MIPS datapath, sitting beside the combinational ALU in the execute stage and owning the architectural HI/LO registers. It accepts one operation at a time via a start/ready handshake and runs shift-add multiply or restoring divide, one bit per cycle. On completion it writes HI/LO and pulses `done`. MTHI/MTLO write HI/LO directly in one cycle.

## Interface
- `WIDTH`, default 32: operand width and HI/LO width; legal values are 8 to 64, even.
- `clk` input, 1 bit: clock; all state changes on the rising edge.
- `reset` input, 1 bit: synchronous, active-high reset.
- `start` input, 1 bit: request; accepted only on an edge where `ready`=1.
- `op` input, `mdu_op_t` (3 bits): MULTU, MULT, DIVU, DIV, MTHI, MTLO.
- `a` input, WIDTH: multiplicand, dividend, or MTHI/MTLO source.
- `b` input, WIDTH: multiplier or divisor; ignored for MTHI/MTLO.
- `ready` output, 1 bit: 1 only in IDLE.
- `busy` output, 1 bit: 1 in CALC, FIX and DONE.
- `done` output, 1 bit: one-cycle pulse in DONE; HI/LO are valid from that cycle.
- `hi` output, WIDTH: HI register; product upper half, or remainder.
- `lo` output, WIDTH: LO register; product lower half, or quotient.

## Operation
- Reset values: state IDLE, `hi`=0, `lo`=0, `ready`=1, `busy`=0, `done`=0, counter=0.
- FSM transitions:
  - IDLE goes to CALC on `start` with a MUL/DIV op.
  - IDLE stays in IDLE on `start` with MTHI/MTLO; the target register is written with `a` on that edge.
  - CALC goes to FIX after WIDTH iterations.
  - FIX goes to DONE.
  - DONE goes to IDLE.
- On acceptance, latch `op`, |a| and |b| (absolute values only for signed ops), and both sign bits. Counter reset to 0.
- MUL datapath: 2·WIDTH-bit accumulator, shift-add on the LSB of the multiplier, one bit per CALC cycle.
- DIV datapath: restoring division, 2·WIDTH-bit remainder/quotient shift register, one quotient bit per CALC cycle.
- FIX for MULT: negate the 2·WIDTH product if the operand signs differ.
- FIX for DIV: negate the quotient if the signs differ; the remainder takes the dividend's sign (truncation toward zero).
- Divide by zero, both DIVU and DIV: `lo` = all ones, `hi` = `a` as latched (unsigned original value). No trap.
- DIV overflow, `a` = most-negative value and `b` = −1: `lo` = most-negative value, `hi` = 0. This falls out of the magnitude arithmetic with wrap; no special case beyond WIDTH-bit truncation.
- HI/LO are written only on the FIX→DONE edge (or the MTHI/MTLO edge). They hold their values at all other times, including while busy.
- `start` while not `ready` is ignored and no state changes. `a`, `b` and `op` may change freely after acceptance.
- `reset` mid-operation aborts the operation: IDLE, HI/LO cleared to 0, no `done` pulse.

## Timing
- Start accepted at edge E0. CALC iterates on edges E1..E_WIDTH. FIX at E(WIDTH+1) writes HI/LO.
- `done`=1 during the cycle after E(WIDTH+1), which is WIDTH+2 cycles after the start edge (34 for WIDTH=32).
- `ready` returns after E(WIDTH+2).
- Back-to-back issue: the earliest next start is at E(WIDTH+2)+1 cycle; throughput is one op per WIDTH+3 cycles.
- MTHI/MTLO: value visible on `hi`/`lo` the cycle after the accepting edge; `ready` stays 1.
- Outputs are registered or decoded from state only; there is no combinational path from inputs to outputs.

## Structure
- The shared package (alongside `u32`, `u3`, `u1`) gets `mdu_op_t`, a 3-bit enum with the codes `MDU_MULTU`=0, `MDU_MULT`=1, `MDU_DIVU`=2, `MDU_DIV`=3, `MDU_MTHI`=4, `MDU_MTLO`=5. Codes 6–7 are treated as no-op.
- `mdu_state_t` (IDLE, CALC, FIX, DONE) is local to the module.
- Single module, no sub-modules. The counter is $clog2(WIDTH)+1 bits.

## Test plan
- MULTU with `a`=0xFFFFFFFF, `b`=2 → `done` at start+34 cycles; `hi`=0x00000001, `lo`=0xFFFFFFFE.
- MULT with −3×5 → `hi`=0xFFFFFFFF, `lo`=0xFFFFFFF1. DIV with −7/2 → `lo`=0xFFFFFFFD, `hi`=0xFFFFFFFF. DIVU with 100/7 → `lo`=14, `hi`=2.
- DIVU with 5/0 → `lo`=0xFFFFFFFF, `hi`=5. DIV with 0x80000000/0xFFFFFFFF → `lo`=0x80000000, `hi`=0.
- MTHI with 0x1234 then MTLO with 0x5678 on consecutive cycles → `hi`=0x1234, `lo`=0x5678, `ready` held at 1, no `done`.
- Start a DIVU, pulse `start` with MULT at cycle 5 → ignored; only one `done`, with the DIVU result. Reset at cycle 10 of a MULTU → IDLE, `hi`/`lo`=0, no `done`.
- WIDTH=8 instance: MULT with 0x80×0x80 → `hi`=0x40, `lo`=0x00, `done` at start+10. Randomised 1000 ops compared against `*`, `/`, `%` reference values.

Source files
------------

// File: rtl/mdu_pkg.sv
// rtl/mdu_pkg.sv - shared types for the execute-stage multiply/divide unit
package mdu_pkg;

    typedef logic [31:0] u32;
    typedef logic [2:0]  u3;
    typedef logic        u1;

    // Codes 6 and 7 are unassigned and behave as no-ops.
    typedef enum logic [2:0] {
        MDU_MULTU = 3'd0,
        MDU_MULT  = 3'd1,
        MDU_DIVU  = 3'd2,
        MDU_DIV   = 3'd3,
        MDU_MTHI  = 3'd4,
        MDU_MTLO  = 3'd5
    } mdu_op_t;

    function automatic u1 mdu_is_arith(input mdu_op_t op);
        return op inside {MDU_MULTU, MDU_MULT, MDU_DIVU, MDU_DIV};
    endfunction

    function automatic u1 mdu_is_signed(input mdu_op_t op);
        return op inside {MDU_MULT, MDU_DIV};
    endfunction

    function automatic u1 mdu_is_div(input mdu_op_t op);
        return op inside {MDU_DIVU, MDU_DIV};
    endfunction

endpackage

// File: rtl/mdu.sv
// rtl/mdu.sv - iterative shift-add multiply / restoring divide unit owning HI/LO
module mdu
    import mdu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  mdu_op_t          op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             ready,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CW = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} mdu_state_t;

    mdu_state_t         state;
    mdu_state_t         state_next;
    mdu_op_t            op_q;
    logic               sign_a;
    logic               sign_b;
    logic [WIDTH-1:0]   mag_a;
    logic [WIDTH-1:0]   mag_b;
    logic [2*WIDTH-1:0] acc;
    logic [CW-1:0]      cnt;

    logic               accept;
    logic               accept_arith;
    logic [WIDTH-1:0]   a_mag;
    logic [WIDTH-1:0]   b_mag;
    logic [WIDTH:0]     mul_sum;
    logic [WIDTH:0]     div_rem;
    logic [WIDTH:0]     div_diff;
    logic [2*WIDTH-1:0] acc_step;
    logic               neg_res;
    logic [2*WIDTH-1:0] fix_prod;
    logic [WIDTH-1:0]   fix_quot;
    logic [WIDTH-1:0]   fix_rem;

    assign accept       = start && (state == IDLE);
    assign accept_arith = accept && mdu_is_arith(op);

    assign ready = (state == IDLE);
    assign busy  = (state != IDLE);
    assign done  = (state == DONE);

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (accept_arith) state_next = CALC;
            CALC:    if (cnt == LAST) state_next = FIX;
            FIX:     state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        a_mag = (mdu_is_signed(op) && a[WIDTH-1]) ? -a : a;
        b_mag = (mdu_is_signed(op) && b[WIDTH-1]) ? -b : b;
    end

    // One iteration: multiply adds the multiplicand on the multiplier LSB and
    // shifts right; divide shifts left and subtracts the divisor if it fits.
    always_comb begin
        mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, mag_a} : '0);
        div_rem  = acc[2*WIDTH-1:WIDTH-1];
        div_diff = div_rem - {1'b0, mag_b};
        if (mdu_is_div(op_q)) begin
            if (!div_diff[WIDTH]) begin
                acc_step = {div_diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
            end else begin
                acc_step = {div_rem[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
            end
        end else begin
            acc_step = {mul_sum, acc[WIDTH-1:1]};
        end
    end

    // A zero divisor yields an all-ones quotient from the iteration itself, but
    // the sign fix-up would corrupt it, so the quotient is forced explicitly.
    always_comb begin
        neg_res  = sign_a ^ sign_b;
        fix_prod = neg_res ? -acc : acc;
        if (mag_b == '0) begin
            fix_quot = '1;
        end else begin
            fix_quot = neg_res ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
        end
        fix_rem = sign_a ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            op_q   <= MDU_MULTU;
            sign_a <= 1'b0;
            sign_b <= 1'b0;
            mag_a  <= '0;
            mag_b  <= '0;
            acc    <= '0;
            cnt    <= '0;
            hi     <= '0;
            lo     <= '0;
        end else begin
            if (accept_arith) begin
                op_q   <= op;
                sign_a <= mdu_is_signed(op) && a[WIDTH-1];
                sign_b <= mdu_is_signed(op) && b[WIDTH-1];
                mag_a  <= a_mag;
                mag_b  <= b_mag;
                acc    <= {{WIDTH{1'b0}}, (mdu_is_div(op) ? a_mag : b_mag)};
                cnt    <= '0;
            end else if (state == CALC) begin
                acc <= acc_step;
                cnt <= cnt + 1'b1;
            end

            if (accept && (op == MDU_MTHI)) hi <= a;
            if (accept && (op == MDU_MTLO)) lo <= a;

            if (state == FIX) begin
                if (mdu_is_div(op_q)) begin
                    hi <= fix_rem;
                    lo <= fix_quot;
                end else begin
                    hi <= fix_prod[2*WIDTH-1:WIDTH];
                    lo <= fix_prod[WIDTH-1:0];
                end
            end
        end
    end

endmodule

// File: tb/tb_mdu.sv
// tb/tb_mdu.sv - randomised and directed bench for mdu at WIDTH 32 and 8
module tb_mdu;
    import mdu_pkg::*;

    logic        clk = 1'b0;
    logic        reset;

    logic        start32;
    mdu_op_t     op32;
    logic [31:0] a32, b32, hi32, lo32;
    logic        ready32, busy32, done32;

    logic        start8;
    mdu_op_t     op8;
    logic [7:0]  a8, b8, hi8, lo8;
    logic        ready8, busy8, done8;

    int checks = 0;
    int fails  = 0;

    always #5 clk = ~clk;

    mdu #(.WIDTH(32)) dut32 (
        .clk(clk), .reset(reset), .start(start32), .op(op32), .a(a32), .b(b32),
        .ready(ready32), .busy(busy32), .done(done32), .hi(hi32), .lo(lo32)
    );

    mdu #(.WIDTH(8)) dut8 (
        .clk(clk), .reset(reset), .start(start8), .op(op8), .a(a8), .b(b8),
        .ready(ready8), .busy(busy8), .done(done8), .hi(hi8), .lo(lo8)
    );

    // Reference: plain integer arithmetic on sign-extended 64-bit values.
    function automatic void model(input int w, input int o, input logic [63:0] xi, yi,
                                  output logic [63:0] rh, output logic [63:0] rl);
        logic [63:0] mask, x, y, p;
        longint sx, sy, q, r;
        mask = (64'd1 << w) - 64'd1;
        x = xi & mask;
        y = yi & mask;
        sx = x[w-1] ? longint'(x) - (longint'(1) << w) : longint'(x);
        sy = y[w-1] ? longint'(y) - (longint'(1) << w) : longint'(y);
        p = 64'd0;
        rh = 64'd0;
        rl = 64'd0;
        if (o == 0 || o == 1) begin
            p = (o == 0) ? x * y : 64'(sx * sy);
            rh = (p >> w) & mask;
            rl = p & mask;
        end else if (y == 64'd0) begin
            rl = mask;
            rh = x;
        end else if (o == 2) begin
            rl = x / y;
            rh = x % y;
        end else begin
            q = sx / sy;
            r = sx % sy;
            rl = 64'(q) & mask;
            rh = 64'(r) & mask;
        end
    endfunction

    function automatic logic [31:0] pick32();
        case ($urandom_range(0, 7))
            0: return 32'h0;
            1: return 32'hFFFF_FFFF;
            2: return 32'h8000_0000;
            3: return 32'(1);
            4: return 32'($urandom_range(0, 15));
            default: return $urandom;
        endcase
    endfunction

    task automatic run32(input mdu_op_t o, input logic [31:0] x, input logic [31:0] y,
                         output logic [31:0] rh, output logic [31:0] rl, output int lat);
        start32 = 1'b1; op32 = o; a32 = x; b32 = y;
        @(posedge clk); #1;
        start32 = 1'b0; op32 = mdu_op_t'($urandom_range(0, 7)); a32 = $urandom; b32 = $urandom;
        lat = -1;
        for (int i = 1; i <= 80; i++) begin
            if (done32 === 1'b1) begin
                lat = i;
                break;
            end
            @(posedge clk); #1;
        end
        rh = hi32;
        rl = lo32;
        if (lat > 0) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic run8(input mdu_op_t o, input logic [7:0] x, input logic [7:0] y,
                        output logic [7:0] rh, output logic [7:0] rl, output int lat);
        start8 = 1'b1; op8 = o; a8 = x; b8 = y;
        @(posedge clk); #1;
        start8 = 1'b0; op8 = mdu_op_t'($urandom_range(0, 7)); a8 = 8'($urandom); b8 = 8'($urandom);
        lat = -1;
        for (int i = 1; i <= 40; i++) begin
            if (done8 === 1'b1) begin
                lat = i;
                break;
            end
            @(posedge clk); #1;
        end
        rh = hi8;
        rl = lo8;
        if (lat > 0) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        start32 = 1'b0; op32 = MDU_MULTU; a32 = '0; b32 = '0;
        start8 = 1'b0; op8 = MDU_MULTU; a8 = '0; b8 = '0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        checks++;
        if ({hi32, lo32, ready32, busy32, done32} !== {64'd0, 3'b100}) begin
            fails++;
            $display("FAIL reset32: hi=%h lo=%h ready=%b busy=%b done=%b, want 0 0 1 0 0",
                     hi32, lo32, ready32, busy32, done32);
        end
        checks++;
        if ({hi8, lo8, ready8, busy8, done8} !== {16'd0, 3'b100}) begin
            fails++;
            $display("FAIL reset8: hi=%h lo=%h ready=%b busy=%b done=%b, want 0 0 1 0 0",
                     hi8, lo8, ready8, busy8, done8);
        end
    endtask

    task automatic test_directed();
        mdu_op_t     ops [6] = '{MDU_MULTU, MDU_MULT, MDU_DIV, MDU_DIVU, MDU_DIVU, MDU_DIV};
        logic [31:0] xs  [6] = '{32'hFFFF_FFFF, 32'hFFFF_FFFD, 32'hFFFF_FFF9, 32'd100, 32'd5, 32'h8000_0000};
        logic [31:0] ys  [6] = '{32'd2, 32'd5, 32'd2, 32'd7, 32'd0, 32'hFFFF_FFFF};
        logic [31:0] ehs [6] = '{32'h1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd2, 32'd5, 32'd0};
        logic [31:0] els [6] = '{32'hFFFF_FFFE, 32'hFFFF_FFF1, 32'hFFFF_FFFD, 32'd14, 32'hFFFF_FFFF, 32'h8000_0000};
        logic [31:0] rh, rl;
        int lat;
        for (int i = 0; i < 6; i++) begin
            run32(ops[i], xs[i], ys[i], rh, rl, lat);
            checks++;
            if (lat !== 34) begin
                fails++;
                $display("FAIL directed%0d latency: got %0d want 34", i, lat);
            end
            checks++;
            if ({rh, rl} !== {ehs[i], els[i]}) begin
                fails++;
                $display("FAIL directed%0d result: hi=%h lo=%h want hi=%h lo=%h", i, rh, rl, ehs[i], els[i]);
            end
            checks++;
            if ({ready32, done32} !== 2'b10) begin
                fails++;
                $display("FAIL directed%0d after: ready=%b done=%b want 1 0", i, ready32, done32);
            end
        end
    endtask

    task automatic test_mt();
        int dones = 0;
        start32 = 1'b1; op32 = MDU_MTHI; a32 = 32'h1234;
        @(posedge clk); #1;
        dones += int'(done32);
        checks++;
        if ({ready32, hi32} !== {1'b1, 32'h1234}) begin
            fails++;
            $display("FAIL mthi: ready=%b hi=%h want 1 00001234", ready32, hi32);
        end
        op32 = MDU_MTLO; a32 = 32'h5678;
        @(posedge clk); #1;
        dones += int'(done32);
        op32 = mdu_op_t'(3'd6); a32 = 32'hDEAD_BEEF;
        @(posedge clk); #1;
        dones += int'(done32);
        start32 = 1'b0;
        checks++;
        if ({ready32, busy32, hi32, lo32} !== {2'b10, 32'h1234, 32'h5678}) begin
            fails++;
            $display("FAIL mtlo: ready=%b busy=%b hi=%h lo=%h want 1 0 00001234 00005678",
                     ready32, busy32, hi32, lo32);
        end
        checks++;
        if (dones != 0) begin
            fails++;
            $display("FAIL mt_done: got %0d pulses want 0", dones);
        end
    endtask

    task automatic test_ignored_start();
        int dones = 0;
        bit held = 1'b1;
        logic [31:0] h0, l0, rh, rl;
        h0 = hi32; l0 = lo32; rh = '0; rl = '0;
        start32 = 1'b1; op32 = MDU_DIVU; a32 = 32'd100; b32 = 32'd7;
        @(posedge clk); #1;
        start32 = 1'b0;
        for (int i = 1; i <= 60; i++) begin
            start32 = (i == 5);
            if (i == 5) begin
                op32 = MDU_MULT; a32 = 32'hFFFF_FFFD; b32 = 32'd5;
                checks++;
                if ({ready32, busy32} !== 2'b01) begin
                    fails++;
                    $display("FAIL busy_flags: ready=%b busy=%b want 0 1", ready32, busy32);
                end
            end
            if (done32 === 1'b1) begin
                dones++;
                rh = hi32; rl = lo32;
            end else if (dones == 0 && (hi32 !== h0 || lo32 !== l0)) begin
                held = 1'b0;
            end
            @(posedge clk); #1;
        end
        start32 = 1'b0;
        checks++;
        if (dones != 1) begin
            fails++;
            $display("FAIL ignored_start pulses: got %0d want 1", dones);
        end
        checks++;
        if ({rh, rl} !== {32'd2, 32'd14}) begin
            fails++;
            $display("FAIL ignored_start result: hi=%h lo=%h want 2 14", rh, rl);
        end
        checks++;
        if (!held) begin
            fails++;
            $display("FAIL hold_while_busy: hi/lo changed before done, got 0 want 1");
        end
    endtask

    task automatic test_reset_abort();
        int dones = 0;
        start32 = 1'b1; op32 = MDU_MULTU; a32 = 32'hFFFF_FFFF; b32 = 32'd2;
        @(posedge clk); #1;
        start32 = 1'b0;
        repeat (9) @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        checks++;
        if ({hi32, lo32, ready32, busy32, done32} !== {64'd0, 3'b100}) begin
            fails++;
            $display("FAIL reset_abort: hi=%h lo=%h ready=%b busy=%b done=%b want 0 0 1 0 0",
                     hi32, lo32, ready32, busy32, done32);
        end
        for (int i = 0; i < 50; i++) begin
            dones += int'(done32);
            @(posedge clk); #1;
        end
        checks++;
        if (dones != 0) begin
            fails++;
            $display("FAIL reset_abort_done: got %0d pulses want 0", dones);
        end
    endtask

    task automatic test_w8_directed();
        logic [7:0] rh, rl;
        int lat;
        run8(MDU_MULT, 8'h80, 8'h80, rh, rl, lat);
        checks++;
        if (lat !== 10) begin
            fails++;
            $display("FAIL w8_latency: got %0d want 10", lat);
        end
        checks++;
        if ({rh, rl} !== 16'h4000) begin
            fails++;
            $display("FAIL w8_mult: hi=%h lo=%h want 40 00", rh, rl);
        end
    endtask

    task automatic test_random32();
        logic [31:0] x, y, rh, rl;
        logic [63:0] eh, el;
        mdu_op_t o;
        int lat;
        for (int n = 0; n < 1000; n++) begin
            o = mdu_op_t'($urandom_range(0, 3));
            x = pick32();
            y = pick32();
            model(32, int'(o), 64'(x), 64'(y), eh, el);
            run32(o, x, y, rh, rl, lat);
            checks++;
            if (lat != 34) begin
                fails++;
                $display("FAIL rand32_latency op=%0d a=%h b=%h: got %0d want 34", o, x, y, lat);
                if (lat < 0) break;
            end
            checks++;
            if ({rh, rl} !== {eh[31:0], el[31:0]}) begin
                fails++;
                $display("FAIL rand32 op=%0d a=%h b=%h: hi=%h lo=%h want hi=%h lo=%h",
                         o, x, y, rh, rl, eh[31:0], el[31:0]);
            end
        end
    endtask

    task automatic test_random8();
        logic [7:0] x, y, rh, rl;
        logic [63:0] eh, el;
        mdu_op_t o;
        int lat;
        for (int n = 0; n < 1000; n++) begin
            o = mdu_op_t'($urandom_range(0, 3));
            x = 8'($urandom);
            y = ($urandom_range(0, 5) == 0) ? 8'($urandom_range(0, 1) * 255) : 8'($urandom);
            model(8, int'(o), 64'(x), 64'(y), eh, el);
            run8(o, x, y, rh, rl, lat);
            checks++;
            if (lat != 10) begin
                fails++;
                $display("FAIL rand8_latency op=%0d a=%h b=%h: got %0d want 10", o, x, y, lat);
                if (lat < 0) break;
            end
            checks++;
            if ({rh, rl} !== {eh[7:0], el[7:0]}) begin
                fails++;
                $display("FAIL rand8 op=%0d a=%h b=%h: hi=%h lo=%h want hi=%h lo=%h",
                         o, x, y, rh, rl, eh[7:0], el[7:0]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_mt();
        test_ignored_start();
        test_reset_abort();
        test_w8_directed();
        test_random32();
        test_random8();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
